// File: rtl/msrv32_ahb_master_arbiter.sv
// msrv32_ahb_master_arbiter
//   Shares one AHB-lite master port between the msrv32 instruction-fetch and
//   data-access requesters. Address phase is combinational from the current
//   requests; the data phase is tracked by an owner register so completions
//   (HREADY) are routed back to whichever requester issued the transfer.
//   Data wins arbitration unless fetch has lost STARVE_LIMIT grants in a row.
// Ports
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-high reset
//   i_* : fetch requester (req/addr in; gnt/rdata/ready/err out)
//   d_* : data requester (req/wr/addr/wdata/wmask in; gnt/rdata/ready/err out)
//   ahb_* : AHB-lite master port (haddr/htrans/hwrite/hsize/hwstrb/hwdata out;
//           hrdata/hready/hresp in)
module msrv32_ahb_master_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic        i_gnt_out,
  output logic [31:0] i_rdata_out,
  output logic        i_ready_out,
  output logic        i_err_out,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_wmask_in,
  output logic        d_gnt_out,
  output logic [31:0] d_rdata_out,
  output logic        d_ready_out,
  output logic        d_err_out,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [3:0]  ahb_hwstrb_out,
  output logic [31:0] ahb_hwdata_out,
  input  logic [31:0] ahb_hrdata_in,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } own_e;

  own_e          dph_own;
  own_e          winner;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   hwdata_q;
  logic          free;
  logic          starved;
  logic          done;

  assign free    = (dph_own == OWN_NONE) | ahb_hready_in;
  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign done    = (dph_own != OWN_NONE) & ahb_hready_in;

  // Gated by reset so that no grant or NONSEQ escapes while reset is held.
  always_comb begin
    winner = OWN_NONE;
    if (!ms_riscv32_mp_rst_in && free) begin
      if (starved && i_req_in)  winner = OWN_INSTR;
      else if (d_req_in)        winner = OWN_DATA;
      else if (i_req_in)        winner = OWN_INSTR;
    end
  end

  always_comb begin
    i_gnt_out      = 1'b0;
    d_gnt_out      = 1'b0;
    ahb_haddr_out  = '0;
    ahb_htrans_out = 2'b00;
    ahb_hwrite_out = 1'b0;
    ahb_hwstrb_out = '0;
    unique case (winner)
      OWN_DATA: begin
        d_gnt_out      = 1'b1;
        ahb_htrans_out = 2'b10;
        ahb_haddr_out  = d_addr_in;
        ahb_hwrite_out = d_wr_in;
        ahb_hwstrb_out = d_wr_in ? d_wmask_in : 4'b0000;
      end
      OWN_INSTR: begin
        i_gnt_out      = 1'b1;
        ahb_htrans_out = 2'b10;
        ahb_haddr_out  = i_addr_in;
      end
      default: ;
    endcase
  end

  assign ahb_hsize_out  = 3'b010;
  assign ahb_hwdata_out = hwdata_q;

  always_comb begin
    i_ready_out = 1'b0;
    i_rdata_out = '0;
    i_err_out   = 1'b0;
    d_ready_out = 1'b0;
    d_rdata_out = '0;
    d_err_out   = 1'b0;
    if (done && dph_own == OWN_INSTR) begin
      i_ready_out = 1'b1;
      i_rdata_out = ahb_hrdata_in;
      i_err_out   = ahb_hresp_in;
    end
    if (done && dph_own == OWN_DATA) begin
      d_ready_out = 1'b1;
      d_rdata_out = ahb_hrdata_in;
      d_err_out   = ahb_hresp_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      dph_own    <= OWN_NONE;
      starve_cnt <= '0;
      hwdata_q   <= '0;
    end else begin
      if (free) begin
        dph_own <= winner;
        if (winner == OWN_DATA && d_wr_in) hwdata_q <= d_wdata_in;
      end
      // winner is NONE while the bus is stalled, so the count only moves on grants.
      if (!i_req_in || winner == OWN_INSTR) starve_cnt <= '0;
      else if (winner == OWN_DATA && !starved) starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule
